// File: rtl/edge_pulse_gen_pkg.sv
// Shared constants for the multi-channel level-to-pulse converter.
// Edge-select mode encodings, pulse FSM state encoding and edge qualifier helper.
// Imported by the channel, the top level and the bench.
package edge_pulse_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_st_e;

  // True when a level change towards new_lvl is a direction the mode wants reported.
  function automatic logic edge_enabled(input logic [1:0] mode, input logic new_lvl);
    logic en;
    case (mode)
      MODE_RISE: en = new_lvl;
      MODE_FALL: en = ~new_lvl;
      MODE_BOTH: en = 1'b1;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Level-in / pulse-out bundle of the edge pulse generator.
// master = the side driving levels and mode; slave = the converter itself.
// No handshake: levels are sampled every cycle, pulses are one-shot.
interface edge_pulse_gen_if #(
  parameter int CH = 4
);
  import edge_pulse_pkg::*;

  logic [CH-1:0] L;
  logic [1:0]    mode;
  logic [CH-1:0] P;
  logic [CH-1:0] level;
  logic          any_p;

  modport master (output L, mode, input P, level, any_p);
  modport slave  (input L, mode, output P, level, any_p);
endinterface

// File: rtl/edge_pulse_gen_ch.sv
// One channel: optional 2-flop sync, debounce filter, edge detect, pulse-width FSM.
// Latency L -> P/level is 2*SYNC + max(DEBOUNCE,1) cycles; P lasts PULSE_W cycles.
// No backpressure: events retrigger (extend) a pulse already in progress.
module edge_pulse_ch
  import edge_pulse_pkg::*;
#(
  parameter int SYNC     = 1,
  parameter int DEBOUNCE = 4,
  parameter int PULSE_W  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l_i,
  input  logic [1:0] mode_i,
  output logic       p_o,
  output logic       p_nxt_o,
  output logic       level_o
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int WW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic raw;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] sync_q;
      // Two-stage synchroniser for the asynchronous level input.
      always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], l_i};
      end
      assign raw = sync_q[1];
    end else begin : g_nosync
      assign raw = l_i;
    end
  endgenerate

  logic          s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce: a new level must persist DEBOUNCE consecutive cycles; any return clears the count.
  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    if (DEBOUNCE == 0) begin
      s_d   = raw;
      cnt_d = '0;
    end else if (raw == s_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
      s_d   = raw;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounced level and its persistence counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  // An event is an accepted level change in a direction the current mode reports.
  logic ev;
  assign ev = (s_d != s_q) && edge_enabled(mode_i, s_d);

  pulse_st_e     st_q;
  logic [WW-1:0] wcnt_q;
  logic          p_q;
  logic          p_nxt;

  // Next-state pulse value, shared by the FSM and the top-level any_p register.
  assign p_nxt = ev | ((st_q == ST_PULSE) && (wcnt_q != '0));

  // Pulse FSM: load width on event, retrigger reloads, count down to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      wcnt_q <= '0;
      p_q    <= 1'b0;
    end else begin
      p_q <= p_nxt;
      case (st_q)
        ST_IDLE: begin
          if (ev) begin
            st_q   <= ST_PULSE;
            wcnt_q <= WW'(PULSE_W - 1);
          end
        end
        ST_PULSE: begin
          if (ev) begin
            wcnt_q <= WW'(PULSE_W - 1);
          end else if (wcnt_q == '0) begin
            st_q <= ST_IDLE;
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        default: begin
          st_q   <= ST_IDLE;
          wcnt_q <= '0;
        end
      endcase
    end
  end

  assign p_o     = p_q;
  assign p_nxt_o = p_nxt;
  assign level_o = s_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel level-to-pulse converter: CH independent channels plus a registered any_p.
// Latency L -> P/level is 2*SYNC + max(DEBOUNCE,1) cycles; any_p aligned with P.
// No backpressure: outputs are one-shot pulses, consumers must sample every cycle.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int CH       = 4,
  parameter int SYNC     = 1,
  parameter int DEBOUNCE = 4,
  parameter int PULSE_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  edge_pulse_gen_if.slave  bus
);

  logic [CH-1:0] p_w;
  logic [CH-1:0] p_nxt_w;
  logic [CH-1:0] level_w;

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      edge_pulse_ch #(
        .SYNC     (SYNC),
        .DEBOUNCE (DEBOUNCE),
        .PULSE_W  (PULSE_W)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .l_i     (bus.L[i]),
        .mode_i  (bus.mode),
        .p_o     (p_w[i]),
        .p_nxt_o (p_nxt_w[i]),
        .level_o (level_w[i])
      );
    end
  endgenerate

  logic any_p_q, any_p_d;
  assign any_p_d = |p_nxt_w;

  // any_p is built from next-state P so it rises and falls on the same edge as P.
  always_ff @(posedge clk) begin
    if (rst) any_p_q <= 1'b0;
    else     any_p_q <= any_p_d;
  end

  assign bus.P     = p_w;
  assign bus.level = level_w;
  assign bus.any_p = any_p_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: several instances cover the parameter sets.
// Cycle n is the n-th rising edge after an input change; outputs sampled 1 time unit after it.
// Expected values are hand-derived from the latency, debounce and pulse-width rules.
module tb_edge_pulse_gen;
  import edge_pulse_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  edge_pulse_gen_if #(.CH(4)) ia ();
  edge_pulse_gen_if #(.CH(4)) ib ();
  edge_pulse_gen_if #(.CH(4)) ic ();
  edge_pulse_gen_if #(.CH(4)) id ();
  edge_pulse_gen_if #(.CH(4)) ie ();

  edge_pulse_gen #(.CH(4), .SYNC(1), .DEBOUNCE(4), .PULSE_W(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  edge_pulse_gen #(.CH(4), .SYNC(1), .DEBOUNCE(4), .PULSE_W(3)) u_b (.clk(clk), .rst(rst), .bus(ib));
  edge_pulse_gen #(.CH(4), .SYNC(1), .DEBOUNCE(4), .PULSE_W(8)) u_c (.clk(clk), .rst(rst), .bus(ic));
  edge_pulse_gen #(.CH(4), .SYNC(1), .DEBOUNCE(4), .PULSE_W(4)) u_d (.clk(clk), .rst(rst), .bus(id));
  edge_pulse_gen #(.CH(4), .SYNC(0), .DEBOUNCE(0), .PULSE_W(1)) u_e (.clk(clk), .rst(rst), .bus(ie));

  logic [3:0] exp_p, exp_lv;
  logic       exp_a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ia.L = '0; ib.L = '0; ic.L = '0; id.L = '0; ie.L = '0;
    ia.mode = MODE_RISE; ib.mode = MODE_BOTH; ic.mode = MODE_BOTH;
    id.mode = MODE_RISE; ie.mode = MODE_RISE;
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({ia.P, ia.level, ia.any_p} !== 9'd0) begin
      miscompares++; $display("FAIL reset_a got %b want 0", {ia.P, ia.level, ia.any_p});
    end
    vectors++;
    if ({ib.P, ib.level, ib.any_p} !== 9'd0) begin
      miscompares++; $display("FAIL reset_b got %b want 0", {ib.P, ib.level, ib.any_p});
    end
    vectors++;
    if ({ic.P, ic.level, ic.any_p} !== 9'd0) begin
      miscompares++; $display("FAIL reset_c got %b want 0", {ic.P, ic.level, ic.any_p});
    end
    vectors++;
    if ({id.P, id.level, id.any_p} !== 9'd0) begin
      miscompares++; $display("FAIL reset_d got %b want 0", {id.P, id.level, id.any_p});
    end
    vectors++;
    if ({ie.P, ie.level, ie.any_p} !== 9'd0) begin
      miscompares++; $display("FAIL reset_e got %b want 0", {ie.P, ie.level, ie.any_p});
    end
    rst = 1'b0;
    tick();
  endtask

  // L[0] rises and is held: level and P at cycle 6 only; then falls with no pulse in rise mode.
  task automatic test_rise();
    ia.mode = MODE_RISE;
    ia.L = 4'b0001;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_p  = (n == 6) ? 4'b0001 : 4'b0000;
      exp_lv = (n >= 6) ? 4'b0001 : 4'b0000;
      exp_a  = (n == 6);
      vectors++;
      if (ia.P !== exp_p || ia.level !== exp_lv || ia.any_p !== exp_a) begin
        miscompares++;
        $display("FAIL rise n=%0d got P=%b lv=%b any=%b want P=%b lv=%b any=%b",
                 n, ia.P, ia.level, ia.any_p, exp_p, exp_lv, exp_a);
      end
    end
    ia.L = 4'b0000;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_lv = (n >= 6) ? 4'b0000 : 4'b0001;
      vectors++;
      if (ia.P !== 4'b0000 || ia.level !== exp_lv || ia.any_p !== 1'b0) begin
        miscompares++;
        $display("FAIL fall_in_rise_mode n=%0d got P=%b lv=%b any=%b want P=0000 lv=%b any=0",
                 n, ia.P, ia.level, ia.any_p, exp_lv);
      end
    end
  endtask

  // A 3-cycle glitch on L[1] is shorter than the debounce window.
  task automatic test_glitch();
    ia.mode = MODE_RISE;
    ia.L = 4'b0010;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 3) ia.L = 4'b0000;
      vectors++;
      if (ia.P !== 4'b0000 || ia.level !== 4'b0000 || ia.any_p !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch n=%0d got P=%b lv=%b any=%b want all 0",
                 n, ia.P, ia.level, ia.any_p);
      end
    end
  endtask

  // Both-edge mode, 3-cycle pulses: L[2] high for 20 cycles gives pulses at 6 and 26.
  task automatic test_both_width();
    ib.mode = MODE_BOTH;
    ib.L = 4'b0100;
    for (int n = 1; n <= 34; n++) begin
      tick();
      if (n == 20) ib.L = 4'b0000;
      exp_p  = ((n >= 6 && n <= 8) || (n >= 26 && n <= 28)) ? 4'b0100 : 4'b0000;
      exp_lv = (n >= 6 && n < 26) ? 4'b0100 : 4'b0000;
      exp_a  = exp_p[2];
      vectors++;
      if (ib.P !== exp_p || ib.level !== exp_lv || ib.any_p !== exp_a) begin
        miscompares++;
        $display("FAIL both_width n=%0d got P=%b lv=%b any=%b want P=%b lv=%b any=%b",
                 n, ib.P, ib.level, ib.any_p, exp_p, exp_lv, exp_a);
      end
    end
  endtask

  // 8-cycle pulses with events every 6 cycles: P[3] held from 6 through 31.
  task automatic test_back_to_back();
    ic.mode = MODE_BOTH;
    ic.L = 4'b1000;
    for (int n = 1; n <= 36; n++) begin
      tick();
      if (n == 6 || n == 12 || n == 18) ic.L = ic.L ^ 4'b1000;
      exp_p = (n >= 6 && n <= 31) ? 4'b1000 : 4'b0000;
      exp_a = exp_p[3];
      vectors++;
      if (ic.P !== exp_p || ic.any_p !== exp_a) begin
        miscompares++;
        $display("FAIL retrigger n=%0d got P=%b any=%b want P=%b any=%b",
                 n, ic.P, ic.any_p, exp_p, exp_a);
      end
    end
  endtask

  // Reset while a 4-cycle pulse is high; held input re-fires 6 cycles after release.
  task automatic test_mid_pulse_reset();
    id.mode = MODE_RISE;
    id.L = 4'b0001;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_p = (n >= 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if (id.P !== exp_p) begin
        miscompares++;
        $display("FAIL pre_reset n=%0d got P=%b want P=%b", n, id.P, exp_p);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (id.P !== 4'b0000 || id.level !== 4'b0000 || id.any_p !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_pulse_reset got P=%b lv=%b any=%b want all 0", id.P, id.level, id.any_p);
    end
    for (int m = 1; m <= 12; m++) begin
      tick();
      exp_p  = (m >= 6 && m <= 9) ? 4'b0001 : 4'b0000;
      exp_lv = (m >= 6) ? 4'b0001 : 4'b0000;
      exp_a  = exp_p[0];
      vectors++;
      if (id.P !== exp_p || id.level !== exp_lv || id.any_p !== exp_a) begin
        miscompares++;
        $display("FAIL post_reset m=%0d got P=%b lv=%b any=%b want P=%b lv=%b any=%b",
                 m, id.P, id.level, id.any_p, exp_p, exp_lv, exp_a);
      end
    end
  endtask

  // No sync, no debounce: one-edge latency, fall ignored, mode off suppresses, all channels at once.
  task automatic test_direct();
    ie.mode = MODE_RISE;
    ie.L = 4'b0010;
    for (int n = 1; n <= 3; n++) begin
      tick();
      exp_p = (n == 1) ? 4'b0010 : 4'b0000;
      vectors++;
      if (ie.P !== exp_p || ie.level !== 4'b0010 || ie.any_p !== exp_p[1]) begin
        miscompares++;
        $display("FAIL direct_rise n=%0d got P=%b lv=%b any=%b want P=%b lv=0010",
                 n, ie.P, ie.level, ie.any_p, exp_p);
      end
    end
    ie.L = 4'b0000;
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if (ie.P !== 4'b0000 || ie.level !== 4'b0000) begin
        miscompares++;
        $display("FAIL direct_fall n=%0d got P=%b lv=%b want P=0000 lv=0000", n, ie.P, ie.level);
      end
    end
    ie.mode = MODE_OFF;
    ie.L = 4'b1111;
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if (ie.P !== 4'b0000 || ie.level !== 4'b1111 || ie.any_p !== 1'b0) begin
        miscompares++;
        $display("FAIL mode_off n=%0d got P=%b lv=%b any=%b want P=0000 lv=1111 any=0",
                 n, ie.P, ie.level, ie.any_p);
      end
    end
    ie.L = 4'b0000;
    tick(); tick();
    ie.mode = MODE_RISE;
    ie.L = 4'b1111;
    for (int n = 1; n <= 3; n++) begin
      tick();
      exp_p = (n == 1) ? 4'b1111 : 4'b0000;
      exp_a = (n == 1);
      vectors++;
      if (ie.P !== exp_p || ie.any_p !== exp_a) begin
        miscompares++;
        $display("FAIL all_channels n=%0d got P=%b any=%b want P=%b any=%b",
                 n, ie.P, ie.any_p, exp_p, exp_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_both_width();
    test_back_to_back();
    test_mid_pulse_reset();
    test_direct();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
